// File: rtl/mem_sys_pkg.sv
// Shared types and defaults for the program/data memory arbiter: region bases,
// FSM state encoding and requester port ids.
package mem_sys_pkg;

  localparam logic [31:0] ROM_BASE_DEFAULT = 32'h0040_0000;
  localparam logic [31:0] RAM_BASE_DEFAULT = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

endpackage

// File: rtl/mem_access_arbiter_if.sv
// Bundle of fetch port, data port and memory port signals; slave is the arbiter's
// view, master is the surrounding core/memory view.
interface mem_access_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [31:0]           i_addr;
  logic                  i_rsp_valid;
  logic [DATA_WIDTH-1:0] i_rdata;
  logic                  i_err;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_we;
  logic [31:0]           d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic                  d_rsp_valid;
  logic [DATA_WIDTH-1:0] d_rdata;
  logic                  d_err;

  logic                  mem_we;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  busy;

  modport slave (
    input  i_req_valid, i_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
    output i_req_ready, i_rsp_valid, i_rdata, i_err,
           d_req_ready, d_rsp_valid, d_rdata, d_err,
           mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output i_req_valid, i_addr, d_req_valid, d_we, d_addr, d_wdata, mem_rdata,
    input  i_req_ready, i_rsp_valid, i_rdata, i_err,
           d_req_ready, d_rsp_valid, d_rdata, d_err,
           mem_we, mem_addr, mem_wdata, busy
  );

endinterface

// File: rtl/mem_addr_check.sv
// Combinational address legality: word aligned, inside ROM or RAM region, and
// never a write into ROM. Bounds compared in 33 bits so base+size cannot wrap.
module mem_addr_check
  import mem_sys_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 64,
  parameter logic [31:0] ROM_BASE     = ROM_BASE_DEFAULT,
  parameter logic [31:0] RAM_BASE     = RAM_BASE_DEFAULT
) (
  input  logic [31:0] addr_i,
  input  logic        we_i,
  output logic        legal_o
);

  localparam logic [32:0] REGION_BYTES = 33'(4 * MEMORY_DEPTH);
  localparam logic [32:0] ROM_LO       = {1'b0, ROM_BASE};
  localparam logic [32:0] RAM_LO       = {1'b0, RAM_BASE};

  logic [32:0] addr_w;
  logic        aligned;
  logic        in_rom;
  logic        in_ram;

  assign addr_w  = {1'b0, addr_i};
  assign aligned = (addr_i[1:0] == 2'b00);
  assign in_rom  = (addr_w >= ROM_LO) && (addr_w < (ROM_LO + REGION_BYTES));
  assign in_ram  = (addr_w >= RAM_LO) && (addr_w < (RAM_LO + REGION_BYTES));

  assign legal_o = aligned && (in_ram || (in_rom && !we_i));

endmodule

// File: rtl/mem_access_arbiter.sv
// Arbitrates fetch and data requesters onto one memory port, IDLE->ACCESS->RESP.
// Define MEM_ARB_RR_EN for round-robin tie-break; otherwise the data port wins ties.
module mem_access_arbiter
  import mem_sys_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 64,
  parameter int          DATA_WIDTH   = 32,
  parameter logic [31:0] ROM_BASE     = ROM_BASE_DEFAULT,
  parameter logic [31:0] RAM_BASE     = RAM_BASE_DEFAULT
) (
  input  logic                 CLK,
  input  logic                 RST,
  mem_access_arbiter_if.slave  bus
);

  state_t                state_q;
  port_t                 port_q;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic                  i_rsp_valid_q;
  logic [DATA_WIDTH-1:0] i_rdata_q;
  logic                  i_err_q;
  logic                  d_rsp_valid_q;
  logic [DATA_WIDTH-1:0] d_rdata_q;
  logic                  d_err_q;

  port_t grant_d;
  logic  idle_w;
  logic  i_ready_w;
  logic  d_ready_w;
  logic  accept_w;
  logic  legal_w;

`ifdef MEM_ARB_RR_EN
  port_t last_grant_q;
`endif

  // Tie-break only matters when both ports ask in the same IDLE cycle.
  always_comb begin
    grant_d = PORT_D;
    if (bus.i_req_valid && bus.d_req_valid) begin
`ifdef MEM_ARB_RR_EN
      grant_d = (last_grant_q == PORT_D) ? PORT_I : PORT_D;
`else
      grant_d = PORT_D;
`endif
    end else if (bus.i_req_valid) begin
      grant_d = PORT_I;
    end
  end

  assign idle_w    = (state_q == ST_IDLE);
  assign i_ready_w = idle_w && bus.i_req_valid && (grant_d == PORT_I);
  assign d_ready_w = idle_w && bus.d_req_valid && (grant_d == PORT_D);
  assign accept_w  = i_ready_w || d_ready_w;

  mem_addr_check #(
    .MEMORY_DEPTH (MEMORY_DEPTH),
    .ROM_BASE     (ROM_BASE),
    .RAM_BASE     (RAM_BASE)
  ) u_addr_check (
    .addr_i  (addr_q),
    .we_i    (we_q),
    .legal_o (legal_w)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      port_q        <= PORT_I;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      i_rsp_valid_q <= 1'b0;
      i_rdata_q     <= '0;
      i_err_q       <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      d_rdata_q     <= '0;
      d_err_q       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      last_grant_q  <= PORT_D;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_w) begin
            port_q  <= grant_d;
            addr_q  <= (grant_d == PORT_D) ? bus.d_addr : bus.i_addr;
            we_q    <= (grant_d == PORT_D) && bus.d_we;
            wdata_q <= (grant_d == PORT_D) ? bus.d_wdata : '0;
            state_q <= ST_ACCESS;
`ifdef MEM_ARB_RR_EN
            last_grant_q <= grant_d;
`endif
          end
        end
        ST_ACCESS: begin
          // Writes and illegal accesses return zero data.
          if (port_q == PORT_I) begin
            i_rsp_valid_q <= 1'b1;
            i_err_q       <= !legal_w;
            i_rdata_q     <= legal_w ? bus.mem_rdata : '0;
          end else begin
            d_rsp_valid_q <= 1'b1;
            d_err_q       <= !legal_w;
            d_rdata_q     <= (legal_w && !we_q) ? bus.mem_rdata : '0;
          end
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          i_rsp_valid_q <= 1'b0;
          i_rdata_q     <= '0;
          i_err_q       <= 1'b0;
          d_rsp_valid_q <= 1'b0;
          d_rdata_q     <= '0;
          d_err_q       <= 1'b0;
          state_q       <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.i_req_ready = i_ready_w;
  assign bus.d_req_ready = d_ready_w;
  assign bus.i_rsp_valid = i_rsp_valid_q;
  assign bus.i_rdata     = i_rdata_q;
  assign bus.i_err       = i_err_q;
  assign bus.d_rsp_valid = d_rsp_valid_q;
  assign bus.d_rdata     = d_rdata_q;
  assign bus.d_err       = d_err_q;

  assign bus.mem_we    = (state_q == ST_ACCESS) && we_q && legal_w;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = !idle_w;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Directed bench for mem_access_arbiter with a small ROM/RAM model on the memory port.
// Tie-order expectations follow MEM_ARB_RR_EN.
module tb_mem_access_arbiter;

  logic CLK;
  logic RST;
  int   checks;
  int   errors;
  int   we_count;

  logic [31:0] ram [64];

  mem_access_arbiter_if #(.DATA_WIDTH(32)) bus ();

  mem_access_arbiter #(
    .MEMORY_DEPTH (64),
    .DATA_WIDTH   (32),
    .ROM_BASE     (32'h0040_0000),
    .RAM_BASE     (32'h1001_0000)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ROM word k reads as A000_000k; RAM is a writable array.
  always_comb begin
    bus.mem_rdata = 32'h0;
    if (bus.mem_addr >= 32'h0040_0000 && bus.mem_addr < 32'h0040_0100)
      bus.mem_rdata = 32'hA000_0000 | 32'(bus.mem_addr[7:2]);
    else if (bus.mem_addr >= 32'h1001_0000 && bus.mem_addr < 32'h1001_0100)
      bus.mem_rdata = ram[bus.mem_addr[7:2]];
  end

  always @(posedge CLK) begin
    if (bus.mem_we === 1'b1 && bus.mem_addr >= 32'h1001_0000 && bus.mem_addr < 32'h1001_0100)
      ram[bus.mem_addr[7:2]] <= bus.mem_wdata;
  end

  always @(negedge CLK) begin
    if (bus.mem_we === 1'b1) we_count++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Presents one request, waits (bounded) for its ready, then drops it at the
  // negedge inside the ACCESS cycle.
  task automatic issue(input bit pd, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, output bit ok);
    ok = 1'b0;
    if (pd) begin
      bus.d_req_valid = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd;
    end else begin
      bus.i_req_valid = 1'b1; bus.i_addr = a;
    end
    for (int n = 0; n < 10; n++) begin
      #1;
      if (pd ? bus.d_req_ready : bus.i_req_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(posedge CLK);
    @(negedge CLK);
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    bus.d_we        = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    int we0;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (bus.busy !== 1'b0 || bus.i_rsp_valid !== 1'b0 || bus.d_rsp_valid !== 1'b0 ||
        bus.mem_we !== 1'b0 || bus.mem_addr !== 32'h0 || bus.i_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b irsp=%b drsp=%b we=%b addr=%h irdy=%b required all 0",
               bus.busy, bus.i_rsp_valid, bus.d_rsp_valid, bus.mem_we, bus.mem_addr, bus.i_req_ready);
    end
    RST = 1'b0;
    @(negedge CLK);
    we0 = we_count;
    issue(1'b0, 1'b0, 32'h0040_0004, 32'h0, ok);
    RST = 1'b1;
    #1;
    checks++;
    if (!ok || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: ok=%b busy=%b required ok=1 busy=1", ok, bus.busy);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      checks++;
      if (bus.i_rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.mem_we !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_access[%0d]: irsp=%b busy=%b we=%b required 0 0 0",
                 k, bus.i_rsp_valid, bus.busy, bus.mem_we);
      end
    end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.i_rsp_valid !== 1'b0 || bus.busy !== 1'b0 || we_count != we0) begin
      errors++;
      $display("FAIL reset_release: irsp=%b busy=%b we_pulses=%0d required 0 0 0",
               bus.i_rsp_valid, bus.busy, we_count - we0);
    end
  endtask

  task automatic test_fetch();
    bit ok;
    issue(1'b0, 1'b0, 32'h0040_0004, 32'h0, ok);
    #1;
    checks++;
    if (!ok || bus.mem_addr !== 32'h0040_0004 || bus.busy !== 1'b1 || bus.i_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_access: ok=%b addr=%h busy=%b irsp=%b required 1 00400004 1 0",
               ok, bus.mem_addr, bus.busy, bus.i_rsp_valid);
    end
    @(negedge CLK);
    checks++;
    if (bus.i_rsp_valid !== 1'b1 || bus.i_rdata !== 32'hA000_0001 || bus.i_err !== 1'b0 ||
        bus.d_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL fetch_resp: irsp=%b rdata=%h err=%b drsp=%b required 1 a0000001 0 0",
               bus.i_rsp_valid, bus.i_rdata, bus.i_err, bus.d_rsp_valid);
    end
    @(negedge CLK);
    checks++;
    if (bus.i_rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: irsp=%b busy=%b required 0 0", bus.i_rsp_valid, bus.busy);
    end
  endtask

  task automatic test_data_rw();
    bit ok;
    int we0;
    we0 = we_count;
    issue(1'b1, 1'b1, 32'h1001_0008, 32'hDEAD_BEEF, ok);
    #1;
    checks++;
    if (!ok || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h1001_0008 || bus.mem_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL write_access: ok=%b we=%b addr=%h wdata=%h required 1 1 10010008 deadbeef",
               ok, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    @(negedge CLK);
    checks++;
    if (bus.d_rsp_valid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin
      errors++;
      $display("FAIL write_resp: drsp=%b err=%b rdata=%h we=%b required 1 0 0 0",
               bus.d_rsp_valid, bus.d_err, bus.d_rdata, bus.mem_we);
    end
    @(negedge CLK);
    issue(1'b1, 1'b0, 32'h1001_0008, 32'h0, ok);
    @(negedge CLK);
    checks++;
    if (!ok || bus.d_rsp_valid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF || bus.d_err !== 1'b0) begin
      errors++;
      $display("FAIL read_back: ok=%b drsp=%b rdata=%h err=%b required 1 1 deadbeef 0",
               ok, bus.d_rsp_valid, bus.d_rdata, bus.d_err);
    end
    checks++;
    if (we_count != we0 + 1) begin
      errors++;
      $display("FAIL write_pulse_count: got %0d required 1", we_count - we0);
    end
    @(negedge CLK);
    issue(1'b0, 1'b0, 32'h1001_0008, 32'h0, ok);
    @(negedge CLK);
    checks++;
    if (!ok || bus.i_rsp_valid !== 1'b1 || bus.i_rdata !== 32'hDEAD_BEEF || bus.i_err !== 1'b0) begin
      errors++;
      $display("FAIL fetch_ram: ok=%b irsp=%b rdata=%h err=%b required 1 1 deadbeef 0",
               ok, bus.i_rsp_valid, bus.i_rdata, bus.i_err);
    end
    @(negedge CLK);
  endtask

  task automatic test_errors();
    bit          ok;
    int          we0;
    logic [31:0] addrs [4];
    bit          wes   [4];
    addrs[0] = 32'h0040_0000; wes[0] = 1'b1;
    addrs[1] = 32'h1001_0002; wes[1] = 1'b0;
    addrs[2] = 32'h1001_0100; wes[2] = 1'b0;
    addrs[3] = 32'h1001_0100; wes[3] = 1'b1;
    we0 = we_count;
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, wes[k], addrs[k], 32'h1234_5678, ok);
      @(negedge CLK);
      checks++;
      if (!ok || bus.d_rsp_valid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin
        errors++;
        $display("FAIL err_access[%0d] addr=%h: ok=%b drsp=%b err=%b rdata=%h required 1 1 1 0",
                 k, addrs[k], ok, bus.d_rsp_valid, bus.d_err, bus.d_rdata);
      end
      @(negedge CLK);
    end
    issue(1'b0, 1'b0, 32'h0040_0100, 32'h0, ok);
    @(negedge CLK);
    checks++;
    if (!ok || bus.i_rsp_valid !== 1'b1 || bus.i_err !== 1'b1 || bus.i_rdata !== 32'h0) begin
      errors++;
      $display("FAIL fetch_err_bound: ok=%b irsp=%b err=%b rdata=%h required 1 1 1 0",
               ok, bus.i_rsp_valid, bus.i_err, bus.i_rdata);
    end
    @(negedge CLK);
    checks++;
    if (we_count != we0) begin
      errors++;
      $display("FAIL err_no_write: got %0d write pulses required 0", we_count - we0);
    end
  endtask

  task automatic test_tie();
    bit exp_d [4];
    bit got_d [4];
    int nacc;
`ifdef MEM_ARB_RR_EN
    exp_d[0] = 1'b0; exp_d[1] = 1'b1; exp_d[2] = 1'b0; exp_d[3] = 1'b1;
`else
    exp_d[0] = 1'b1; exp_d[1] = 1'b1; exp_d[2] = 1'b1; exp_d[3] = 1'b1;
`endif
    nacc = 0;
    bus.i_req_valid = 1'b1; bus.i_addr = 32'h0040_0008;
    bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0010;
    for (int c = 0; c < 40 && nacc < 4; c++) begin
      #1;
      if (bus.i_req_ready && bus.d_req_ready) begin
        checks++; errors++;
        $display("FAIL tie_double_ready: both readies high in one cycle");
      end
      if (bus.i_req_ready || bus.d_req_ready) begin
        got_d[nacc] = bus.d_req_ready;
        nacc++;
      end
      @(negedge CLK);
    end
    bus.i_req_valid = 1'b0;
    bus.d_req_valid = 1'b0;
    checks++;
    if (nacc != 4) begin
      errors++;
      $display("FAIL tie_timeout: got %0d accepts required 4", nacc);
    end
    for (int k = 0; k < nacc; k++) begin
      checks++;
      if (got_d[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL tie_order[%0d]: got %s required %s", k,
                 got_d[k] ? "D" : "I", exp_d[k] ? "D" : "I");
      end
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    int acc_cyc [4];
    int nacc;
    int low_cnt;
    nacc = 0;
    low_cnt = 0;
    bus.d_req_valid = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h1001_0008;
    for (int c = 0; c < 40 && nacc < 4; c++) begin
      #1;
      if (nacc >= 1 && bus.busy == 1'b0) low_cnt++;
      if (bus.d_req_ready) begin
        acc_cyc[nacc] = c;
        nacc++;
      end
      @(negedge CLK);
    end
    bus.d_req_valid = 1'b0;
    checks++;
    if (nacc != 4) begin
      errors++;
      $display("FAIL b2b_timeout: got %0d accepts required 4", nacc);
    end else begin
      for (int k = 1; k < 4; k++) begin
        checks++;
        if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
          errors++;
          $display("FAIL b2b_spacing[%0d]: got %0d cycles required 3", k, acc_cyc[k] - acc_cyc[k-1]);
        end
      end
      checks++;
      if (low_cnt != 3) begin
        errors++;
        $display("FAIL b2b_busy_low: got %0d idle cycles over 3 gaps required 3", low_cnt);
      end
    end
    repeat (3) @(negedge CLK);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    we_count = 0;
    for (int k = 0; k < 64; k++) ram[k] = 32'h5000_0000 | k;
    RST = 1'b1;
    bus.i_req_valid = 1'b0; bus.i_addr = 32'h0;
    bus.d_req_valid = 1'b0; bus.d_we = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    test_reset();
    test_fetch();
    test_data_rw();
    test_errors();
    test_tie();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
